fusion_result_streamer: RTL and testbench
=========================================

# fusion_result_streamer

Output-side companion to `fusion_top`. It captures each Kalman state vector that `fusion_top` presents with its `valid_out` pulse, buffers whole frames in a small FIFO, and serializes them onto a valid/ready word stream. Each frame is one header word followed by the state words, so a downstream consumer (host link, logger, DMA) can drain results without back-pressuring the filter.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of each state word and stream word; must be ≥ 16.
- `STATE_WIDTH`, 2, number of state words per frame.
- `FIFO_DEPTH`, 4, number of frames buffered; must be a power of 2 and ≥ 2.
- `CNT_WIDTH`, 8, width of the drop counter.

Ports:
- `clk`, in, 1, single clock; all logic is on its rising edge.
- `rst_n`, in, 1, asynchronous, active-low reset.
- `kalman_in`, in, `DATA_WIDTH` x `STATE_WIDTH` (unpacked array), state vector from `fusion_top` `kalman_out`.
- `kalman_valid`, in, 1, connected to `fusion_top` `valid_out`.
- `m_data`, out, `DATA_WIDTH`, stream word.
- `m_valid`, out, 1, stream word valid.
- `m_ready`, in, 1, consumer accepts the word.
- `m_first`, out, 1, high on the header word.
- `m_last`, out, 1, high on the final state word.
- `drop_count`, out, `CNT_WIDTH`, saturating count of frames lost to a full FIFO.
- `busy`, out, 1, high while the FIFO is non-empty or a frame is in flight.

## Operation
- **Capture.** Every cycle with `kalman_valid`=1 is one frame. The state vector is written into the FIFO with the current 8-bit sequence number `seq`.
- **Sequence number.** `seq` increments (mod 256) only when a frame is accepted.
- **Full FIFO.**
  - A frame arriving while the FIFO is full is dropped.
  - On a drop, `drop_count` increments and saturates at all-ones; `seq` does not change.
  - A write and the pop of the last word of the oldest frame in the same cycle counts as not full. The write is accepted.
- **Frame format.**
  - Word 0 is the header: `m_data[DATA_WIDTH-1:8]` = `HDR_MARKER` (0xA5 in the low 8 bits of that field, upper bits zero), and `m_data[7:0]` = `seq`.
  - Words 1..`STATE_WIDTH` are `kalman_in[0]`..`kalman_in[STATE_WIDTH-1]`.
- **State machine.**
  - `IDLE`: move to `HEADER` when the FIFO is not empty.
  - `HEADER`: on handshake, move to `PAYLOAD` with word index 0.
  - `PAYLOAD`: on each handshake, increment the index. On the handshake at index `STATE_WIDTH`-1, pop the FIFO, then go to `HEADER` if another frame remains (checked after any same-cycle write), else to `IDLE`.
- **Handshake.**
  - A transfer occurs on a cycle with `m_valid` && `m_ready`.
  - Once `m_valid` rises, it stays high, and `m_data`/`m_first`/`m_last` stay stable, until that transfer.
  - `m_valid`=0 in `IDLE`.
  - `m_first`=1 only in `HEADER`. `m_last`=1 only at index `STATE_WIDTH`-1.
- **Arithmetic.** The word index is ceil(log2(`STATE_WIDTH`+1)) bits wide. FIFO pointers are log2(`FIFO_DEPTH`)+1 bits wide, with the wrap bit used to detect full/empty.

## Timing
- **Reset values.** `m_valid`=0, `m_data`=0, `m_first`=0, `m_last`=0, `drop_count`=0, `busy`=0, `seq`=0, FIFO empty, state `IDLE`.
- **Capture latency.** `kalman_valid` high at cycle N into an empty FIFO gives `m_valid`=1 with the header at N+1 (registered outputs).
- **Throughput.**
  - With `m_ready` held high, a frame takes `STATE_WIDTH`+1 cycles.
  - Back-to-back frames stream with no idle cycle.
  - The header of the next frame follows the `m_last` transfer on the next cycle.
- **Drop timing.** `drop_count` updates the cycle after the dropped `kalman_valid`.
- **Reset mid-frame.** Assertion immediately clears all state; a partial frame is lost and not resumed.
- **Back-to-back input.** `kalman_valid` held high for K cycles produces K frames, or drops once full.

## Structure
- Package `fusion_stream_pkg` holds:
  - default `DATA_WIDTH` and `STATE_WIDTH`;
  - `HDR_MARKER` = 8'hA5;
  - `SEQ_WIDTH` = 8;
  - the FSM enum `stream_state_t` {`IDLE`, `HEADER`, `PAYLOAD`};
  - a packed frame struct {`seq`, `state` words}.
- Sub-module `fusion_frame_fifo`: synchronous FIFO of frame structs with `wr_en`, `rd_en`, `full`, `empty`, first-word-fall-through read data.
- The top module contains the FSM, sequence/drop counters and the output registers.

## Test plan
- **Single frame.** After reset, pulse `kalman_valid` with `kalman_in`={109,138} and `m_ready`=1. Expect 0xA500 (`first`), 109, 138 (`last`) on consecutive cycles starting 1 cycle after the pulse; then `busy`=0.
- **Back-pressure.** Same frame with `m_ready` low for 3 cycles on each word. Expect `m_data`/`m_first`/`m_last` stable while stalled, no duplicated or skipped words, `seq`=0x00.
- **Burst.** Hold `kalman_valid` high 10 cycles with `m_ready`=0, `FIFO_DEPTH`=4. Expect `drop_count`=6, then 4 frames with headers 0xA500..0xA503.
- **Full-boundary.** FIFO full while the `m_last` handshake and `kalman_valid` occur in the same cycle. Expect the frame accepted, `drop_count` unchanged, and its header following immediately.
- **Wrap and saturation.** Stream 300 accepted frames and check the header `seq` wraps 0xFF→0x00. Force 260 drops and check `drop_count` saturates at 255.
- **Reset mid-frame.** Assert `rst_n`=0 while `m_valid`=1 in `PAYLOAD`. Expect all outputs 0 within the reset cycle. The next frame after release carries header 0xA500.

Source files
------------

// File: rtl/fusion_result_streamer_pkg.sv
// Shared definitions for the fusion result streamer.
// Holds default widths, the header marker, the stream FSM state type,
// the default-width frame struct and a small sequence helper.
package fusion_stream_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 16;
  localparam int DEFAULT_STATE_WIDTH = 2;
  localparam int SEQ_WIDTH           = 8;
  localparam logic [7:0] HDR_MARKER  = 8'hA5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HEADER  = 2'd1,
    PAYLOAD = 2'd2
  } stream_state_t;

  // One buffered frame: sequence number plus the state words, word 0 lowest.
  typedef struct packed {
    logic [SEQ_WIDTH-1:0]                                    seq;
    logic [DEFAULT_STATE_WIDTH-1:0][DEFAULT_DATA_WIDTH-1:0]  state;
  } frame_t;

  // Sequence numbers wrap modulo 2**SEQ_WIDTH.
  function automatic logic [SEQ_WIDTH-1:0] seq_next(input logic [SEQ_WIDTH-1:0] s);
    return s + 8'd1;
  endfunction

endpackage

// File: rtl/fusion_result_streamer_if.sv
// Valid/ready word stream carrying serialized fusion frames.
// Signals: m_data (word), m_valid, m_ready, m_first (header), m_last (final word).
// master: producer side (streamer); slave: consumer side.
interface fusion_result_streamer_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_first;
  logic                  m_last;

  modport master (output m_data, output m_valid, output m_first, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_first, input m_last, output m_ready);
endinterface

// File: rtl/fusion_result_streamer_fifo.sv
// Synchronous frame FIFO with first-word-fall-through read data.
// Ports: clk, rst_n (async active-low), wr_en/wr_data, rd_en/rd_data,
// full, empty, count (frames held). Pointers carry an extra wrap bit.
// A write while full is taken only when a read retires a slot in the same cycle.
module fusion_frame_fifo
  import fusion_stream_pkg::*;
#(
  parameter int WIDTH = $bits(frame_t),
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wr_ptr_r;
  logic [PW-1:0]    rd_ptr_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  assign full    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign empty   = (wr_ptr_r == rd_ptr_r);
  assign count   = wr_ptr_r - rd_ptr_r;
  assign wr_ok_s = wr_en && (!full || rd_ok_s);
  assign rd_ok_s = rd_en && !empty;
  assign rd_data = mem_r[rd_ptr_r[AW-1:0]];

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
    end else begin
      if (wr_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (rd_ok_s) rd_ptr_r <= rd_ptr_r + PW'(1);
    end
  end

  // Frame storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
  end
endmodule

// File: rtl/fusion_result_streamer.sv
// Captures Kalman state vectors, buffers whole frames and serializes them as
// header word ({HDR_MARKER, seq}) followed by STATE_WIDTH state words.
// Ports: clk, rst_n (async active-low), kalman_in/kalman_valid (capture side),
// m (stream master: m_data, m_valid, m_ready, m_first, m_last),
// drop_count (saturating frames lost to a full FIFO), busy.
module fusion_result_streamer
  import fusion_stream_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int STATE_WIDTH = DEFAULT_STATE_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] kalman_in [STATE_WIDTH],
  input  logic                  kalman_valid,
  fusion_result_streamer_if.master m,
  output logic [CNT_WIDTH-1:0]  drop_count,
  output logic                  busy
);
  localparam int IDX_W = $clog2(STATE_WIDTH + 1);
  localparam int PW    = $clog2(FIFO_DEPTH) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STATE_WIDTH - 1);

  typedef struct packed {
    logic [SEQ_WIDTH-1:0]                    seq;
    logic [STATE_WIDTH-1:0][DATA_WIDTH-1:0]  state;
  } local_frame_t;

  stream_state_t          state_r;
  logic [IDX_W-1:0]       idx_r;
  logic [IDX_W-1:0]       nxt_idx_s;
  logic [SEQ_WIDTH-1:0]   seq_r;
  logic [CNT_WIDTH-1:0]   drop_r;
  logic [DATA_WIDTH-1:0]  m_data_r;
  logic                   m_valid_r;
  logic                   m_first_r;
  logic                   m_last_r;
  logic                   busy_r;
  local_frame_t           wr_frame_s;
  local_frame_t           rd_frame_s;
  logic [$bits(local_frame_t)-1:0] rd_bits_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [PW-1:0]          fifo_count_s;
  logic                   pop_s;
  logic                   accept_s;
  logic                   drop_s;
  logic                   more_s;

  function automatic logic [DATA_WIDTH-1:0] hdr_word(input logic [SEQ_WIDTH-1:0] s);
    logic [DATA_WIDTH-1:0] w;
    w       = {DATA_WIDTH{1'b0}};
    w[15:8] = HDR_MARKER;
    w[7:0]  = s;
    return w;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] pick_word(
    input logic [STATE_WIDTH-1:0][DATA_WIDTH-1:0] words,
    input logic [IDX_W-1:0] idx
  );
    logic [DATA_WIDTH-1:0] w;
    w = {DATA_WIDTH{1'b0}};
    for (int i = 0; i < STATE_WIDTH; i++) begin
      if (idx == IDX_W'(i)) w = words[i];
    end
    return w;
  endfunction

  // The last payload handshake retires the oldest frame; a write in that same
  // cycle reuses the slot, so a full FIFO still accepts it.
  assign pop_s     = (state_r == PAYLOAD) && m.m_ready && (idx_r == LAST_IDX);
  assign accept_s  = kalman_valid && (!fifo_full_s || pop_s);
  assign drop_s    = kalman_valid && fifo_full_s && !pop_s;
  assign more_s    = (fifo_count_s > PW'(1)) || accept_s;
  assign nxt_idx_s = idx_r + IDX_W'(1);
  assign rd_frame_s = rd_bits_s;

  // Pack the incoming vector with its sequence number.
  always_comb begin
    wr_frame_s.seq = seq_r;
    for (int i = 0; i < STATE_WIDTH; i++) begin
      wr_frame_s.state[i] = kalman_in[i];
    end
  end

  fusion_frame_fifo #(
    .WIDTH ($bits(local_frame_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept_s),
    .wr_data (wr_frame_s),
    .rd_en   (pop_s),
    .rd_data (rd_bits_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s),
    .count   (fifo_count_s)
  );

  // Sequence number and saturating drop counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq_r  <= {SEQ_WIDTH{1'b0}};
      drop_r <= {CNT_WIDTH{1'b0}};
    end else begin
      if (accept_s) seq_r <= seq_next(seq_r);
      if (drop_s && (drop_r != {CNT_WIDTH{1'b1}})) drop_r <= drop_r + CNT_WIDTH'(1);
    end
  end

  // Stream FSM with registered outputs. Accepted frames carry consecutive
  // sequence numbers, so the next header is the current frame's seq + 1;
  // from IDLE with an empty FIFO the frame being written now carries seq_r.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      m_data_r  <= {DATA_WIDTH{1'b0}};
      m_valid_r <= 1'b0;
      m_first_r <= 1'b0;
      m_last_r  <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (!fifo_empty_s || accept_s) begin
            state_r   <= HEADER;
            m_data_r  <= hdr_word(fifo_empty_s ? seq_r : rd_frame_s.seq);
            m_valid_r <= 1'b1;
            m_first_r <= 1'b1;
            m_last_r  <= 1'b0;
            busy_r    <= 1'b1;
          end
        end
        HEADER: begin
          if (m.m_ready) begin
            state_r   <= PAYLOAD;
            idx_r     <= {IDX_W{1'b0}};
            m_data_r  <= pick_word(rd_frame_s.state, {IDX_W{1'b0}});
            m_first_r <= 1'b0;
            m_last_r  <= (LAST_IDX == {IDX_W{1'b0}});
          end
        end
        PAYLOAD: begin
          if (m.m_ready) begin
            if (idx_r == LAST_IDX) begin
              if (more_s) begin
                state_r   <= HEADER;
                m_data_r  <= hdr_word(seq_next(rd_frame_s.seq));
                m_first_r <= 1'b1;
                m_last_r  <= 1'b0;
              end else begin
                state_r   <= IDLE;
                m_data_r  <= {DATA_WIDTH{1'b0}};
                m_valid_r <= 1'b0;
                m_first_r <= 1'b0;
                m_last_r  <= 1'b0;
                busy_r    <= 1'b0;
              end
            end else begin
              idx_r    <= nxt_idx_s;
              m_data_r <= pick_word(rd_frame_s.state, nxt_idx_s);
              m_last_r <= (nxt_idx_s == LAST_IDX);
            end
          end
        end
        default: begin
          state_r   <= IDLE;
          m_valid_r <= 1'b0;
          m_first_r <= 1'b0;
          m_last_r  <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign m.m_data    = m_data_r;
  assign m.m_valid   = m_valid_r;
  assign m.m_first   = m_first_r;
  assign m.m_last    = m_last_r;
  assign drop_count  = drop_r;
  assign busy        = busy_r;
endmodule

// File: tb/tb_fusion_result_streamer.sv
// Directed self-checking bench for fusion_result_streamer (default parameters).
module tb_fusion_result_streamer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] kin [2];
  logic        kv = 1'b0;
  logic [7:0]  drop_count;
  logic        busy;
  int          errors = 0;
  int          checks = 0;

  fusion_result_streamer_if #(.DATA_WIDTH(16)) bus ();

  fusion_result_streamer #(
    .DATA_WIDTH (16),
    .STATE_WIDTH(2),
    .FIFO_DEPTH (4),
    .CNT_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .kalman_in    (kin),
    .kalman_valid (kv),
    .m            (bus),
    .drop_count   (drop_count),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [15:0] d, input logic f, input logic l);
    chk({tag, ".valid"}, {31'd0, bus.m_valid}, 32'd1);
    chk({tag, ".data"},  {16'd0, bus.m_data},  {16'd0, d});
    chk({tag, ".first"}, {31'd0, bus.m_first}, {31'd0, f});
    chk({tag, ".last"},  {31'd0, bus.m_last},  {31'd0, l});
  endtask

  // Called at a negedge with the header presented and m_ready high.
  task automatic expect_frame(input string tag, input logic [7:0] seq,
                              input logic [15:0] w0, input logic [15:0] w1);
    logic [15:0] hdr;
    hdr = {8'hA5, seq};
    chk_word({tag, ".hdr"}, hdr, 1'b1, 1'b0);
    tick();
    chk_word({tag, ".w0"}, w0, 1'b0, 1'b0);
    tick();
    chk_word({tag, ".w1"}, w1, 1'b0, 1'b1);
    tick();
  endtask

  // Hold m_ready low for 3 cycles, checking the word stays put, then take it.
  task automatic stall_word(input string tag, input logic [15:0] d, input logic f, input logic l);
    bus.m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_word(tag, d, f, l);
      tick();
    end
    chk_word(tag, d, f, l);
    bus.m_ready = 1'b1;
    tick();
  endtask

  task automatic do_reset();
    kv = 1'b0;
    bus.m_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    logic [7:0] exp_drop;
    kin[0] = 16'd0;
    kin[1] = 16'd0;
    bus.m_ready = 1'b0;
    tick();
    // Reset state
    chk("rst.valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst.data",  {16'd0, bus.m_data},  32'd0);
    chk("rst.first", {31'd0, bus.m_first}, 32'd0);
    chk("rst.last",  {31'd0, bus.m_last},  32'd0);
    chk("rst.drop",  {24'd0, drop_count},  32'd0);
    chk("rst.busy",  {31'd0, busy},        32'd0);
    rst_n = 1'b1;
    tick();

    // Single frame, header one cycle after the pulse
    kin[0] = 16'd109; kin[1] = 16'd138; kv = 1'b1; bus.m_ready = 1'b1;
    tick();
    kv = 1'b0;
    expect_frame("single", 8'h00, 16'd109, 16'd138);
    chk("single.idle_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("single.busy",       {31'd0, busy},        32'd0);

    // Back-pressure
    do_reset();
    kin[0] = 16'd109; kin[1] = 16'd138; kv = 1'b1;
    tick();
    kv = 1'b0;
    stall_word("bp.hdr", 16'hA500, 1'b1, 1'b0);
    stall_word("bp.w0", 16'd109, 1'b0, 1'b0);
    stall_word("bp.w1", 16'd138, 1'b0, 1'b1);
    chk("bp.idle_valid", {31'd0, bus.m_valid}, 32'd0);

    // Burst of 10 into a 4-deep FIFO with the consumer stalled
    do_reset();
    for (int j = 0; j < 10; j++) begin
      kin[0] = 16'(j); kin[1] = 16'(100 + j); kv = 1'b1;
      tick();
      exp_drop = (j >= 4) ? 8'(j - 3) : 8'd0;
      chk("burst.drop_step", {24'd0, drop_count}, {24'd0, exp_drop});
    end
    kv = 1'b0;
    chk("burst.drop", {24'd0, drop_count}, 32'd6);
    bus.m_ready = 1'b1;
    for (int j = 0; j < 4; j++) begin
      expect_frame("burst", 8'(j), 16'(j), 16'(100 + j));
    end
    chk("burst.idle_valid", {31'd0, bus.m_valid}, 32'd0);

    // Write while full, coinciding with the m_last handshake
    do_reset();
    for (int j = 0; j < 4; j++) begin
      kin[0] = 16'(10 + j); kin[1] = 16'(20 + j); kv = 1'b1;
      tick();
    end
    kv = 1'b0;
    bus.m_ready = 1'b1;
    chk_word("full.hdr0", 16'hA500, 1'b1, 1'b0);
    tick();
    chk_word("full.w0", 16'd10, 1'b0, 1'b0);
    tick();
    chk_word("full.w1", 16'd20, 1'b0, 1'b1);
    kin[0] = 16'd77; kin[1] = 16'd88; kv = 1'b1;
    tick();
    kv = 1'b0;
    chk("full.drop", {24'd0, drop_count}, 32'd0);
    for (int j = 1; j < 4; j++) begin
      expect_frame("full.f", 8'(j), 16'(10 + j), 16'(20 + j));
    end
    expect_frame("full.new", 8'h04, 16'd77, 16'd88);
    chk("full.idle_valid", {31'd0, bus.m_valid}, 32'd0);

    // Sequence wrap over 300 accepted frames
    do_reset();
    bus.m_ready = 1'b1;
    for (int n = 0; n < 300; n++) begin
      kin[0] = 16'(n); kin[1] = 16'(n) ^ 16'hFFFF; kv = 1'b1;
      tick();
      kv = 1'b0;
      expect_frame("wrap", 8'(n), 16'(n), 16'(n) ^ 16'hFFFF);
    end

    // Drop counter saturation: 4 accepted, 260 dropped
    do_reset();
    for (int j = 0; j < 264; j++) begin
      kin[0] = 16'(j); kin[1] = 16'h5000 + 16'(j); kv = 1'b1;
      tick();
      exp_drop = (j >= 258) ? 8'd255 : ((j >= 4) ? 8'(j - 3) : 8'd0);
      chk("sat.drop_step", {24'd0, drop_count}, {24'd0, exp_drop});
    end
    kv = 1'b0;
    chk("sat.drop", {24'd0, drop_count}, 32'd255);

    // Reset mid-frame while in PAYLOAD
    bus.m_ready = 1'b1;
    chk_word("mid.hdr", 16'hA500, 1'b1, 1'b0);
    tick();
    bus.m_ready = 1'b0;
    chk_word("mid.w0", 16'd0, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid.valid", {31'd0, bus.m_valid}, 32'd0);
    chk("mid.data",  {16'd0, bus.m_data},  32'd0);
    chk("mid.first", {31'd0, bus.m_first}, 32'd0);
    chk("mid.last",  {31'd0, bus.m_last},  32'd0);
    chk("mid.drop",  {24'd0, drop_count},  32'd0);
    chk("mid.busy",  {31'd0, busy},        32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    bus.m_ready = 1'b1;
    kin[0] = 16'd7; kin[1] = 16'd8; kv = 1'b1;
    tick();
    kv = 1'b0;
    expect_frame("mid.after", 8'h00, 16'd7, 16'd8);
    chk("mid.idle_valid", {31'd0, bus.m_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
